// File: rtl/uart_rx_sampler.sv
// Oversampling bit sampler for a UART receiver: counts oversample ticks and bits, strobes the recovered bit at mid-bit.
// Optional build macro MAJORITY_VOTE_EN enables 3-tap majority voting around the mid-bit sample.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  enable,
    input  logic                  data_samp_en,
    output logic                  sampled_data,
    output logic                  sampled,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    localparam logic [PRESCALE_W-1:0] PS_MIN   = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] PS_RESET = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO      = PRESCALE_W'(2);

    logic [PRESCALE_W-1:0] ps_reg, ps_next;
    logic [PRESCALE_W-1:0] ps_clamped;
    logic [PRESCALE_W-1:0] edge_reg, edge_next;
    logic [3:0]            bit_reg, bit_next;
    logic                  sampled_reg, sampled_next;
    logic                  data_reg, data_next;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] last_edge;
    logic                  strobe;
    logic                  recovered;

    assign mid       = ps_reg >> 1;
    assign last_edge = ps_reg - ONE;

    // Ratio is only re-latched while idle, so the counters never see it change mid-frame.
    always_comb begin
        ps_clamped = {Prescale[PRESCALE_W-1:1], 1'b0};
        if (Prescale < PS_MIN) begin
            ps_clamped = PS_MIN;
        end
        ps_next = ps_reg;
        if (!enable) begin
            ps_next = ps_clamped;
        end
    end

    always_comb begin
        edge_next = edge_reg;
        bit_next  = bit_reg;
        if (!enable) begin
            edge_next = '0;
            bit_next  = '0;
        end else if (edge_reg >= last_edge) begin
            edge_next = '0;
            bit_next  = bit_reg + 4'd1;
        end else begin
            edge_next = edge_reg + ONE;
        end
    end

`ifdef MAJORITY_VOTE_EN
    // Taps at mid-2 and mid-1; mid itself comes straight from the line.
    logic [1:0] vote;

    for (genvar gi = 0; gi < 2; gi++) begin : g_vote
        logic tap_reg;

        always_ff @(posedge CLK) begin
            if (Reset) begin
                tap_reg <= 1'b0;
            end else if (enable && (edge_reg == mid - TWO + PRESCALE_W'(gi))) begin
                tap_reg <= RX_IN;
            end
        end

        assign vote[gi] = tap_reg;
    end

    assign recovered = (vote[0] & vote[1]) | (vote[0] & RX_IN) | (vote[1] & RX_IN);
`else
    assign recovered = RX_IN;
`endif

    always_comb begin
        strobe       = enable && data_samp_en && (edge_reg == mid);
        sampled_next = strobe;
        data_next    = data_reg;
        if (strobe) begin
            data_next = recovered;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ps_reg      <= PS_RESET;
            edge_reg    <= '0;
            bit_reg     <= '0;
            sampled_reg <= 1'b0;
            data_reg    <= 1'b1;
        end else begin
            ps_reg      <= ps_next;
            edge_reg    <= edge_next;
            bit_reg     <= bit_next;
            sampled_reg <= sampled_next;
            data_reg    <= data_next;
        end
    end

    assign edge_cnt     = edge_reg;
    assign bit_cnt      = bit_reg;
    assign sampled      = sampled_reg;
    assign sampled_data = data_reg;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: expected bits are queued as stimulus is driven, popped on each strobe.
module tb_uart_rx_sampler;

    localparam int W = 6;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         RX_IN;
    logic [W-1:0] Prescale;
    logic         enable;
    logic         data_samp_en;
    logic         sampled_data;
    logic         sampled;
    logic [W-1:0] edge_cnt;
    logic [3:0]   bit_cnt;

    int   pass_cnt   = 0;
    int   total_cnt  = 0;
    int   strobe_cnt = 0;
    logic exp_q[$];

    uart_rx_sampler #(.PRESCALE_W(W)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .enable       (enable),
        .data_samp_en (data_samp_en),
        .sampled_data (sampled_data),
        .sampled      (sampled),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt)
    );

    always #5 CLK = ~CLK;

    // Every strobe consumes one queued expectation; a strobe with nothing queued is an error.
    always @(negedge CLK) begin
        if (sampled === 1'b1) begin
            logic want;
            strobe_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe got sampled_data=%b want no strobe", sampled_data);
            end else begin
                want = exp_q.pop_front();
                if (sampled_data !== want)
                    $display("FAIL strobe_data got %b want %b", sampled_data, want);
                else
                    pass_cnt++;
            end
            $display("strobe #%0d at %0t: sampled_data=%b", strobe_cnt, $time, sampled_data);
        end
    end

    task automatic cyc(input logic rx, input logic en, input logic dse);
        RX_IN        = rx;
        enable       = en;
        data_samp_en = dse;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Prescale = 6'd16;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1);
        total_cnt++; if (edge_cnt !== 6'd0) $display("FAIL reset_edge_cnt got %0d want 0", edge_cnt); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 4'd0) $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); else pass_cnt++;
        total_cnt++; if (sampled !== 1'b0) $display("FAIL reset_sampled got %b want 0", sampled); else pass_cnt++;
        total_cnt++; if (sampled_data !== 1'b1) $display("FAIL reset_sampled_data got %b want 1", sampled_data); else pass_cnt++;
        // Leaving reset with enable already high: ratio must still be the reset value 8.
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd0) $display("FAIL reset_ps8_edge got %0d want 0", edge_cnt); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 4'd1) $display("FAIL reset_ps8_bit got %0d want 1", bit_cnt); else pass_cnt++;
        cyc(1'b1, 1'b0, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) $display("FAIL idle_clear got edge=%0d bit=%0d want 0/0", edge_cnt, bit_cnt); else pass_cnt++;
    endtask

    task automatic test_basic();
        Prescale = 6'd8;
        cyc(1'b1, 1'b0, 1'b0);
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (k == 3) begin
                total_cnt++; if (edge_cnt !== 6'd4 || sampled !== 1'b0) $display("FAIL basic_at_mid got edge=%0d sampled=%b want 4/0", edge_cnt, sampled); else pass_cnt++;
            end
            if (k == 4) begin
                total_cnt++; if (sampled !== 1'b1 || sampled_data !== 1'b0) $display("FAIL basic_strobe got sampled=%b data=%b want 1/0", sampled, sampled_data); else pass_cnt++;
            end
            if (k == 5) begin
                total_cnt++; if (sampled !== 1'b0) $display("FAIL basic_one_cycle got sampled=%b want 0", sampled); else pass_cnt++;
            end
        end
        total_cnt++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd1) $display("FAIL basic_wrap got edge=%0d bit=%0d want 0/1", edge_cnt, bit_cnt); else pass_cnt++;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        total_cnt++; if (exp_q.size() != 0) $display("FAIL basic_pending got %0d want 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_vote();
        int   s0;
        logic rx_v;
        Prescale = 6'd16;
        cyc(1'b1, 1'b0, 1'b0);
        s0 = strobe_cnt;
`ifdef MAJORITY_VOTE_EN
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
`else
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
`endif
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 16; k++) begin
`ifdef MAJORITY_VOTE_EN
                rx_v = (b == 0) ? (k != 7) : !(k == 6 || k == 7);
`else
                rx_v = (b == 0) ? (k != 8) : (k != 7);
`endif
                cyc(rx_v, 1'b1, 1'b1);
            end
        end
        cyc(1'b1, 1'b0, 1'b0);
        total_cnt++; if (strobe_cnt - s0 != 2 || exp_q.size() != 0) $display("FAIL vote_strobes got %0d want 2", strobe_cnt - s0); else pass_cnt++;
    endtask

    task automatic test_frame();
        int         s0;
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        Prescale = 6'd16;
        cyc(1'b1, 1'b0, 1'b0);
        s0 = strobe_cnt;
        for (int i = 0; i < 10; i++) exp_q.push_back(fr[i]);
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < 16; k++) cyc(fr[i], 1'b1, 1'b1);
        total_cnt++; if (bit_cnt !== 4'd10 || edge_cnt !== 6'd0) $display("FAIL frame_counters got bit=%0d edge=%0d want 10/0", bit_cnt, edge_cnt); else pass_cnt++;
        total_cnt++; if (strobe_cnt - s0 != 10 || exp_q.size() != 0) $display("FAIL frame_strobes got %0d want 10", strobe_cnt - s0); else pass_cnt++;
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_enable_drop();
        int s0;
        Prescale = 6'd8;
        cyc(1'b1, 1'b0, 1'b0);
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b1);
        total_cnt++; if (edge_cnt !== 6'd3) $display("FAIL drop_pre_edge got %0d want 3", edge_cnt); else pass_cnt++;
        cyc(1'b1, 1'b0, 1'b1);
        total_cnt++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0 || sampled !== 1'b0) $display("FAIL drop_clear got edge=%0d bit=%0d sampled=%b want 0/0/0", edge_cnt, bit_cnt, sampled); else pass_cnt++;
        s0 = strobe_cnt;
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0);
        total_cnt++; if (strobe_cnt != s0 || sampled_data !== 1'b0) $display("FAIL drop_gated got strobes=%0d data=%b want 0/0", strobe_cnt - s0, sampled_data); else pass_cnt++;
        total_cnt++; if (bit_cnt !== 4'd1) $display("FAIL drop_bit_cnt got %0d want 1", bit_cnt); else pass_cnt++;
        // Only the data_samp_en value in the mid cycle matters.
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, k != 4);
        total_cnt++; if (strobe_cnt != s0 || sampled_data !== 1'b0) $display("FAIL dse_low_at_mid got strobes=%0d data=%b want 0/0", strobe_cnt - s0, sampled_data); else pass_cnt++;
        exp_q.push_back(1'b1);
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, k == 4);
        total_cnt++; if (strobe_cnt - s0 != 1 || sampled_data !== 1'b1 || exp_q.size() != 0) $display("FAIL dse_high_at_mid got strobes=%0d data=%b want 1/1", strobe_cnt - s0, sampled_data); else pass_cnt++;
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_prescale_change();
        Prescale = 6'd8;
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) cyc(1'b1, 1'b1, 1'b0);
        Prescale = 6'd32;
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd1) $display("FAIL ps_hold got edge=%0d bit=%0d want 0/1", edge_cnt, bit_cnt); else pass_cnt++;
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 31; k++) cyc(1'b1, 1'b1, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd31 || bit_cnt !== 4'd0) $display("FAIL ps32_top got edge=%0d bit=%0d want 31/0", edge_cnt, bit_cnt); else pass_cnt++;
        cyc(1'b1, 1'b1, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd1) $display("FAIL ps32_wrap got edge=%0d bit=%0d want 0/1", edge_cnt, bit_cnt); else pass_cnt++;
        Prescale = 6'd3;
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd3) $display("FAIL ps3_top got edge=%0d want 3", edge_cnt); else pass_cnt++;
        cyc(1'b1, 1'b1, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd1) $display("FAIL ps3_wrap got edge=%0d bit=%0d want 0/1", edge_cnt, bit_cnt); else pass_cnt++;
        exp_q.push_back(1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b1);
        total_cnt++; if (exp_q.size() != 0 || sampled_data !== 1'b0) $display("FAIL ps4_sample got pending=%0d data=%b want 0/0", exp_q.size(), sampled_data); else pass_cnt++;
        Prescale = 6'd9;
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd1) $display("FAIL ps9_wrap got edge=%0d bit=%0d want 0/1", edge_cnt, bit_cnt); else pass_cnt++;
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int s0;
        Prescale = 6'd8;
        cyc(1'b1, 1'b0, 1'b0);
        s0 = strobe_cnt;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1);
        Reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        total_cnt++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) $display("FAIL rstmid_counters got edge=%0d bit=%0d want 0/0", edge_cnt, bit_cnt); else pass_cnt++;
        total_cnt++; if (sampled !== 1'b0 || sampled_data !== 1'b1) $display("FAIL rstmid_outputs got sampled=%b data=%b want 0/1", sampled, sampled_data); else pass_cnt++;
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 1'b0);
        total_cnt++; if (edge_cnt !== 6'd6 || strobe_cnt != s0) $display("FAIL rstmid_resume got edge=%0d strobes=%0d want 6/0", edge_cnt, strobe_cnt - s0); else pass_cnt++;
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        Reset        = 1'b1;
        RX_IN        = 1'b1;
        enable       = 1'b0;
        data_samp_en = 1'b0;
        Prescale     = 6'd8;
        test_reset();
        test_basic();
        test_vote();
        test_frame();
        test_enable_drop();
        test_prescale_change();
        test_reset_mid();
        cyc(1'b1, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
